// File: rtl/fpmult_seq_param.sv
// Sequential floating-point multiplier with a sign | exponent | fraction layout.
// The significand product is formed by a shift-add loop that retires RB multiplier
// bits per cycle. A single ROUND cycle then normalises, rounds, packs and flags.
// The result is held under a valid/ack handshake.
module fpmult_seq_param #(
    parameter int EW = 8,
    parameter int FW = 7,
    parameter int RB = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [EW+FW:0]   x_in,
    input  logic [EW+FW:0]   y_in,
    input  logic [1:0]       round_in,
    input  logic             start_in,
    input  logic             ack_in,
    output logic [EW+FW:0]   p_out,
    output logic [3:0]       oor_out,
    output logic             valid_out,
    output logic             ready_out
);
    // state | meaning
    // IDLE  | waiting for start_in, ready_out high
    // MULT  | shift-add iterations; the counter reaching 0 hands over to ROUND
    // ROUND | normalise/round/pack; special results also register here
    // HOLD  | result valid, waiting for ack_in

    localparam int SW  = FW + 1;
    localparam int PW  = 2 * SW;
    localparam int N   = (SW + RB - 1) / RB;
    localparam int NRB = N * RB;
    localparam int AW  = SW + NRB;
    localparam int XW  = EW + 2;
    localparam int CW  = $clog2(N + 1);
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_ROUND, S_HOLD} state_t;
    state_t state, nxt;

    // operand fields
    logic [EW-1:0] ex, ey;
    logic [FW-1:0] fx, fy;
    logic          x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic          spec;
    logic [EW+FW:0] spec_p;
    logic [3:0]    spec_f;
    logic signed [XW-1:0] exe, eye;
    logic          accept;

    assign ex = x_in[EW+FW-1:FW];
    assign ey = y_in[EW+FW-1:FW];
    assign fx = x_in[FW-1:0];
    assign fy = y_in[FW-1:0];
    assign x_nan  = (&ex) && (fx != '0);
    assign y_nan  = (&ey) && (fy != '0);
    assign x_inf  = (&ex) && (fx == '0);
    assign y_inf  = (&ey) && (fy == '0);
    assign x_zero = (ex == '0) && (fx == '0);
    assign y_zero = (ey == '0) && (fy == '0);
    // subnormal operands use an effective exponent of 1
    assign exe = (ex == '0) ? XW'(1) : XW'(ex);
    assign eye = (ey == '0) ? XW'(1) : XW'(ey);
    assign accept = start_in && (state == S_IDLE);

    // registered operation context
    logic                 sign_q;
    logic [1:0]           rnd_q;
    logic signed [XW-1:0] erw_q;
    logic [SW-1:0]        ma_q;
    logic [NRB-1:0]       mb_q;
    logic [AW-1:0]        acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 spec_q;
    logic [EW+FW:0]       specp_q;
    logic [3:0]           specf_q;
    logic [AW+RB-1:0]     sum;

    assign sum = (AW+RB)'(acc_q)
               + (((AW+RB)'(ma_q) * (AW+RB)'(mb_q[RB-1:0])) << NRB);

    // special-operand classification in priority order: NaN/inf*0, inf, zero
    always_comb begin
        spec   = 1'b1;
        spec_p = {1'b0, {EW{1'b1}}, FW'(1)};
        spec_f = 4'b0010;
        if (x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf)) begin
            spec_p = {1'b0, {EW{1'b1}}, FW'(1)};
            spec_f = 4'b0010;
        end else if (x_inf || y_inf) begin
            spec_p = {x_in[EW+FW] ^ y_in[EW+FW], {EW{1'b1}}, {FW{1'b0}}};
            spec_f = 4'b0100;
        end else if (x_zero || y_zero) begin
            spec_p = {x_in[EW+FW] ^ y_in[EW+FW], {(EW+FW){1'b0}}};
            spec_f = 4'b1000;
        end else begin
            spec = 1'b0;
        end
    end

    // rounding datapath signals
    logic [PW-1:0]        prod, pn, shd;
    logic [XW-1:0]        lz, sh;
    logic signed [XW-1:0] e, en;
    logic                 uf, lost, g, st, inexact, inc, ovf, to_inf;
    logic [SW-1:0]        keep;
    logic [SW:0]          sig;
    logic [EW+FW:0]       res_p;
    logic [3:0]           res_f;

    assign prod = acc_q[PW-1:0];

    // leading-zero count of the raw product (highest set bit wins)
    always_comb begin
        lz = '0;
        for (int i = 0; i < PW; i++) begin
            if (prod[i]) lz = XW'(PW - 1 - i);
        end
    end

    assign pn      = prod << lz;
    assign e       = erw_q + XW'(1) - lz;
    assign uf      = e[XW-1] || (e == '0);
    assign sh      = XW'(1) - e;
    assign shd     = uf ? (pn >> sh) : pn;
    assign lost    = uf && (|(pn & ~({PW{1'b1}} << sh)));
    assign keep    = shd[PW-1 -: SW];
    assign g       = shd[SW-1];
    assign st      = (|shd[SW-2:0]) | lost;
    assign inexact = g | st;
    assign sig     = {1'b0, keep} + (SW+1)'(inc);
    assign en      = e + XW'(sig[SW]);
    assign ovf     = !uf && (en >= EMAX);

    // rounding increment and overflow direction by mode
    always_comb begin
        case (rnd_q)
            2'b00:   begin inc = g & (st | keep[0]); to_inf = 1'b1;    end
            2'b01:   begin inc = 1'b0;               to_inf = 1'b0;    end
            2'b10:   begin inc = inexact & sign_q;   to_inf = sign_q;  end
            default: begin inc = inexact & ~sign_q;  to_inf = ~sign_q; end
        endcase
    end

    // pack the rounded result and derive its flags
    always_comb begin
        res_p = {sign_q, en[EW-1:0], sig[FW-1:0]};
        res_f = 4'b0000;
        if (uf) begin
            res_p = {sign_q, EW'(sig[SW-1]), sig[FW-1:0]};
        end else if (ovf) begin
            if (to_inf) begin
                res_p = {sign_q, {EW{1'b1}}, {FW{1'b0}}};
                res_f = 4'b0100;
            end else begin
                res_p = {sign_q, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
            end
        end
        if (!ovf && (res_p[EW+FW-1:FW] == '0)) begin
            res_f = {(res_p[FW-1:0] == '0), 2'b00, 1'b1};
        end
    end

    // state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= nxt;
    end

    // next-state logic
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start_in) nxt = spec ? S_ROUND : S_MULT;
            S_MULT:  if (cnt_q == '0) nxt = S_ROUND;
            S_ROUND: nxt = S_HOLD;
            default: if (ack_in) nxt = S_IDLE;
        endcase
    end

    // handshake outputs
    always_comb begin
        valid_out = (state == S_HOLD);
        ready_out = (state == S_IDLE);
    end

    // operand capture, shift-add iterations and result register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sign_q  <= 1'b0;
            rnd_q   <= 2'b00;
            erw_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            spec_q  <= 1'b0;
            specp_q <= '0;
            specf_q <= '0;
            p_out   <= '0;
            oor_out <= '0;
        end else begin
            if (accept) begin
                sign_q  <= x_in[EW+FW] ^ y_in[EW+FW];
                rnd_q   <= round_in;
                erw_q   <= exe + eye - BIAS;
                ma_q    <= {(ex != '0), fx};
                mb_q    <= NRB'({(ey != '0), fy});
                acc_q   <= '0;
                cnt_q   <= CW'(N);
                spec_q  <= spec;
                specp_q <= spec_p;
                specf_q <= spec_f;
            end else if ((state == S_MULT) && (cnt_q != '0)) begin
                acc_q <= sum[AW+RB-1:RB];
                mb_q  <= mb_q >> RB;
                cnt_q <= cnt_q - 1'b1;
            end
            if (state == S_ROUND) begin
                p_out   <= spec_q ? specp_q : res_p;
                oor_out <= spec_q ? specf_q : res_f;
            end
        end
    end

endmodule

// File: tb/tb_fpmult_seq_param.sv
// Bench for fpmult_seq_param: table of bfloat16 vectors with a scoreboard queue,
// plus hand sequences for hold/ack, mid-operation input changes, reset and RB variants.
module tb_fpmult_seq_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] x = '0, y = '0;
    logic [1:0]  rnd = 2'b00;
    logic        ack = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0, start4 = 1'b0;
    logic [15:0] p1, p2, p4;
    logic [3:0]  f1, f2, f4;
    logic        v1, v2, v4, r1, r2, r4;
    logic [1:0]  sel = 2'd0;
    logic [15:0] cp;
    logic [3:0]  cf;
    logic        cv, cr;

    fpmult_seq_param #(.EW(8), .FW(7), .RB(1)) dut1 (
        .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .round_in(rnd),
        .start_in(start1), .ack_in(ack), .p_out(p1), .oor_out(f1),
        .valid_out(v1), .ready_out(r1));

    fpmult_seq_param #(.EW(8), .FW(7), .RB(2)) dut2 (
        .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .round_in(rnd),
        .start_in(start2), .ack_in(ack), .p_out(p2), .oor_out(f2),
        .valid_out(v2), .ready_out(r2));

    fpmult_seq_param #(.EW(8), .FW(7), .RB(4)) dut4 (
        .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .round_in(rnd),
        .start_in(start4), .ack_in(ack), .p_out(p4), .oor_out(f4),
        .valid_out(v4), .ready_out(r4));

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            2'd1:    begin cp = p2; cf = f2; cv = v2; cr = r2; end
            2'd2:    begin cp = p4; cf = f4; cv = v4; cr = r4; end
            default: begin cp = p1; cf = f1; cv = v1; cr = r1; end
        endcase
    end

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  rnd;
        logic [15:0] p;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] xa, input logic [15:0] ya, input logic [1:0] ra,
                       input logic [15:0] pe, input logic [3:0] fe, input int le);
        vec_t v;
        v.x = xa; v.y = ya; v.rnd = ra; v.p = pe; v.f = fe; v.lat = le;
        tbl.push_back(v);
    endtask

    task automatic drive_start(input logic s);
        start1 = (sel == 2'd0) ? s : 1'b0;
        start2 = (sel == 2'd1) ? s : 1'b0;
        start4 = (sel == 2'd2) ? s : 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!cv && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    // one transaction: push expectation at accept, pop and compare at valid
    task automatic run_op(input vec_t v, input string nm, input bit scr);
        vec_t e;
        int   k;
        @(negedge clk);
        chk({nm, " ready"}, cr, 1);
        x = v.x; y = v.y; rnd = v.rnd;
        drive_start(1'b1);
        sbq.push_back(v);
        @(posedge clk); #1;
        drive_start(1'b0);
        if (scr) begin
            x = 16'h0000; y = 16'hFFFF; rnd = ~rnd;
        end
        wait_valid(k);
        e = sbq.pop_front();
        chk({nm, " p"}, cp, e.p);
        chk({nm, " oor"}, cf, e.f);
        chk({nm, " latency"}, k, e.lat);
        @(posedge clk); #1;
        chk({nm, " released"}, cv, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k, seen;
        vec_t v;

        // RNE=0 RTZ=1 RD=2 RU=3
        add(16'h3FC0, 16'h4000, 2'd0, 16'h4040, 4'b0000, 10);
        add(16'h3F81, 16'h3F81, 2'd0, 16'h3F82, 4'b0000, 10);
        add(16'h3F81, 16'h3F81, 2'd3, 16'h3F83, 4'b0000, 10);
        add(16'h3F81, 16'h3F81, 2'd1, 16'h3F82, 4'b0000, 10);
        add(16'hBF81, 16'h3F81, 2'd2, 16'hBF83, 4'b0000, 10);
        add(16'h7F7F, 16'h4000, 2'd0, 16'h7F80, 4'b0100, 10);
        add(16'h7F7F, 16'h4000, 2'd1, 16'h7F7F, 4'b0000, 10);
        add(16'h7F80, 16'h0000, 2'd0, 16'h7F81, 4'b0010, 1);
        add(16'h0080, 16'h3F00, 2'd0, 16'h0040, 4'b0001, 10);
        add(16'h0001, 16'h0001, 2'd0, 16'h0000, 4'b1001, 10);
        add(16'h0001, 16'h0001, 2'd3, 16'h0001, 4'b0001, 10);
        add(16'h3F80, 16'h3F80, 2'd0, 16'h3F80, 4'b0000, 10);
        add(16'hC000, 16'h4040, 2'd0, 16'hC0C0, 4'b0000, 10);
        add(16'h3F81, 16'h3FC0, 2'd0, 16'h3FC2, 4'b0000, 10);
        add(16'h3F81, 16'h3FC0, 2'd1, 16'h3FC1, 4'b0000, 10);
        add(16'h3F83, 16'h3FC0, 2'd0, 16'h3FC4, 4'b0000, 10);
        add(16'h0040, 16'h4300, 2'd0, 16'h0380, 4'b0000, 10);
        add(16'h007F, 16'h3F81, 2'd0, 16'h0080, 4'b0000, 10);
        add(16'h007F, 16'h3F81, 2'd1, 16'h007F, 4'b0001, 10);
        add(16'h3F80, 16'h0001, 2'd0, 16'h0001, 4'b0001, 10);
        add(16'h7F7F, 16'h4000, 2'd2, 16'h7F7F, 4'b0000, 10);
        add(16'h7F7F, 16'h4000, 2'd3, 16'h7F80, 4'b0100, 10);
        add(16'hFF7F, 16'h4000, 2'd2, 16'hFF80, 4'b0100, 10);
        add(16'hFF7F, 16'h4000, 2'd3, 16'hFF7F, 4'b0000, 10);
        add(16'h8001, 16'h0001, 2'd2, 16'h8001, 4'b0001, 10);
        add(16'h8001, 16'h0001, 2'd3, 16'h8000, 4'b1001, 10);
        add(16'h8000, 16'h4000, 2'd0, 16'h8000, 4'b1000, 1);
        add(16'hFF80, 16'h4000, 2'd0, 16'hFF80, 4'b0100, 1);
        add(16'h7FC0, 16'h3F80, 2'd0, 16'h7F81, 4'b0010, 1);
        add(16'h7FC1, 16'h0000, 2'd0, 16'h7F81, 4'b0010, 1);
        add(16'h0000, 16'hFF80, 2'd0, 16'h7F81, 4'b0010, 1);

        // reset state
        #12;
        chk("reset p", p1, 0);
        chk("reset oor", f1, 0);
        chk("reset valid", v1, 0);
        chk("reset ready", r1, 1);
        chk("reset ready rb2", r2, 1);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i), 1'b0);

        // operands and round mode changed right after accept must not matter
        v.x = 16'h3F81; v.y = 16'h3F81; v.rnd = 2'd3; v.p = 16'h3F83; v.f = 4'b0000; v.lat = 10;
        run_op(v, "scramble", 1'b1);

        // hold with ack low for 5 cycles; start during HOLD is ignored
        ack = 1'b0;
        @(negedge clk);
        x = 16'h3FC0; y = 16'h4000; rnd = 2'd0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_valid(k);
        chk("hold latency", k, 10);
        chk("hold p first", p1, 16'h4040);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x = 16'h3F80; y = 16'h3F80; start1 = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("hold%0d valid", i), v1, 1);
            chk($sformatf("hold%0d ready", i), r1, 0);
            chk($sformatf("hold%0d p", i), p1, 16'h4040);
            chk($sformatf("hold%0d oor", i), f1, 0);
        end
        @(negedge clk);
        start1 = 1'b0; ack = 1'b1;
        @(posedge clk); #1;
        chk("ack valid", v1, 0);
        chk("ack ready", r1, 1);
        chk("ack p kept", p1, 16'h4040);
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (v1) seen++;
        end
        chk("ignored start", seen, 0);

        // asynchronous reset in the middle of MULT
        @(negedge clk);
        x = 16'h3F81; y = 16'h3F81; rnd = 2'd0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid busy", r1, 0);
        rst = 1'b1;
        #1;
        chk("async rst p", p1, 0);
        chk("async rst oor", f1, 0);
        chk("async rst valid", v1, 0);
        chk("async rst ready", r1, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("post rst valid", v1, 0);
        run_op(tbl[0], "after rst", 1'b0);

        // RB=2 and RB=4 instances
        sel = 2'd1;
        v.x = 16'h3FC0; v.y = 16'h4000; v.rnd = 2'd0; v.p = 16'h4040; v.f = 4'b0000; v.lat = 6;
        run_op(v, "rb2 t1", 1'b0);
        v.x = 16'h3F81; v.y = 16'h3F81; v.rnd = 2'd3; v.p = 16'h3F83; v.f = 4'b0000; v.lat = 6;
        run_op(v, "rb2 ru", 1'b0);
        v.x = 16'h0001; v.y = 16'h0001; v.rnd = 2'd0; v.p = 16'h0000; v.f = 4'b1001; v.lat = 6;
        run_op(v, "rb2 uf", 1'b0);
        sel = 2'd2;
        v.x = 16'h3FC0; v.y = 16'h4000; v.rnd = 2'd0; v.p = 16'h4040; v.f = 4'b0000; v.lat = 4;
        run_op(v, "rb4 t1", 1'b0);
        v.x = 16'h3F83; v.y = 16'h3FC0; v.rnd = 2'd0; v.p = 16'h3FC4; v.f = 4'b0000; v.lat = 4;
        run_op(v, "rb4 tie", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
